mem_stage_ctrl: RTL and testbench

//  MEM-stage data-memory access controller. Sits directly downstream of the EX/MEM pipeline register.

---
 rtl/mem_stage_ctrl_if.sv | 33 +++
 rtl/mem_stage_ctrl.sv | 151 +++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory bus between the MEM-stage controller and a multi-cycle data memory.
// The controller (master) holds dmem_req until the memory (slave) answers with
// dmem_ack; dmem_rdata is valid in the same cycle as dmem_ack.
interface mem_stage_ctrl_if #(
  parameter int DATA_W = 16
) ();

  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_ack,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_ack,
    output dmem_rdata
  );

endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM-stage data-memory access controller.
// Sits behind the EX/MEM register, runs a req/ack handshake with a multi-cycle
// data memory, freezes the front of the pipeline with mem_stall and hands load
// data to MEM/WB. An access that sees no ack for MAX_WAIT BUSY cycles is
// aborted and raises the sticky mem_err flag.
// Optional feature: define MEM2MEM_FWD_EN to forward MEM/WB write-back data
// into the store data when the store source register matches the MEM/WB
// destination (register 0 never forwards).
// rst is asynchronous and active-low.
module mem_stage_ctrl #(
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [3:0]        SrcReg2,
  input  logic              wb_RegWrite,
  input  logic [3:0]        wb_DstReg,
  input  logic [DATA_W-1:0] wb_data,
  mem_stage_ctrl_if.master  dmem,
  output logic              mem_stall,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              mem_err
);

  localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [CNT_W-1:0]  wait_cnt;
  logic              access;
  logic              timeout;
  logic              stall_c;
  logic [DATA_W-1:0] store_data;

  assign access  = MemRead | MemWrite;
  assign timeout = (wait_cnt == LAST_WAIT) & ~dmem.dmem_ack;

`ifdef MEM2MEM_FWD_EN
  // Pick the store data, replacing a stale register value with the MEM/WB result
  always_comb begin
    store_data = wdata;
    if (MemWrite && wb_RegWrite && (wb_DstReg == SrcReg2) && (wb_DstReg != 4'd0)) begin
      store_data = wb_data;
    end
  end
`else
  assign store_data = wdata;

  logic unused_fwd;
  assign unused_fwd = &{1'b0, SrcReg2, wb_RegWrite, wb_DstReg, wb_data};
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and the raw stall request
  always_comb begin
    next_state = state;
    stall_c    = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          stall_c    = 1'b1;
          next_state = BUSY;
        end
      end
      BUSY: begin
        stall_c = 1'b1;
        if (dmem.dmem_ack || timeout) begin
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Stall is forced low while reset is asserted so the pipeline is released at once
  assign mem_stall = rst & stall_c;

  // Memory request, captured address/data, load result, timeout counter and error flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_wdata <= '0;
      rdata           <= '0;
      rdata_valid     <= 1'b0;
      mem_err         <= 1'b0;
      wait_cnt        <= '0;
    end else begin
      rdata_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (access) begin
            dmem.dmem_req   <= 1'b1;
            dmem.dmem_we    <= MemWrite;
            dmem.dmem_addr  <= addr;
            dmem.dmem_wdata <= store_data;
          end
        end
        BUSY: begin
          if (dmem.dmem_ack) begin
            if (!dmem.dmem_we) begin
              rdata <= dmem.dmem_rdata;
            end
            dmem.dmem_req <= 1'b0;
            rdata_valid   <= ~dmem.dmem_we;
          end else if (timeout) begin
            mem_err       <= 1'b1;
            rdata         <= '0;
            dmem.dmem_req <= 1'b0;
            rdata_valid   <= ~dmem.dmem_we;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE: begin
          wait_cnt <= '0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl.
// Each access is described at transaction level (kind, address, data, ack
// delay) and turned into the per-cycle outputs it must produce; a compare
// process checks the DUT against those every falling edge. Directed cases
// pin the model with hand-computed literals, then randomized accesses follow.
module tb_mem_stage_ctrl;

  localparam int DATA_W   = 16;
  localparam int MAX_WAIT = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        MemRead, MemWrite;
  logic [15:0] addr, wdata, wb_data;
  logic [3:0]  SrcReg2, wb_DstReg;
  logic        wb_RegWrite;
  logic        mem_stall, rdata_valid, mem_err;
  logic [15:0] rdata;

  mem_stage_ctrl_if #(.DATA_W(DATA_W)) dmem_if ();

  mem_stage_ctrl #(.DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .addr(addr), .wdata(wdata), .SrcReg2(SrcReg2),
    .wb_RegWrite(wb_RegWrite), .wb_DstReg(wb_DstReg), .wb_data(wb_data),
    .dmem(dmem_if),
    .mem_stall(mem_stall), .rdata(rdata), .rdata_valid(rdata_valid), .mem_err(mem_err)
  );

  // Free-running clock
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected outputs for the current cycle plus the architectural model state
  logic        cmp_en = 1'b0;
  logic        e_stall, e_req, e_we, e_rv;
  logic [15:0] e_addr, e_wdata;
  logic [15:0] m_rdata;
  logic        m_err;

  // Observation counters used by the literal pins
  int          stall_cnt, req_cnt, rv_cnt;
  logic [15:0] last_addr, last_wdata;
  logic        last_we;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT outputs against the model every falling edge and gather counters
  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("mem_stall", 32'(mem_stall), 32'(e_stall));
      checkOutput("dmem_req", 32'(dmem_if.dmem_req), 32'(e_req));
      if (e_req) begin
        checkOutput("dmem_we", 32'(dmem_if.dmem_we), 32'(e_we));
        checkOutput("dmem_addr", 32'(dmem_if.dmem_addr), 32'(e_addr));
        if (e_we) checkOutput("dmem_wdata", 32'(dmem_if.dmem_wdata), 32'(e_wdata));
      end
      checkOutput("rdata", 32'(rdata), 32'(m_rdata));
      checkOutput("rdata_valid", 32'(rdata_valid), 32'(e_rv));
      checkOutput("mem_err", 32'(mem_err), 32'(m_err));
    end
    if (mem_stall) stall_cnt++;
    if (rdata_valid) rv_cnt++;
    if (dmem_if.dmem_req) begin
      req_cnt++;
      last_addr  = dmem_if.dmem_addr;
      last_wdata = dmem_if.dmem_wdata;
      last_we    = dmem_if.dmem_we;
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic setExp(input logic st, input logic rq, input logic we,
                        input logic [15:0] a, input logic [15:0] wd, input logic rv);
    e_stall = st; e_req = rq; e_we = we; e_addr = a; e_wdata = wd; e_rv = rv;
  endtask

  task automatic clearCounters();
    stall_cnt = 0; req_cnt = 0; rv_cnt = 0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      nextCycle();
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      addr     = 16'($urandom);
      wdata    = 16'($urandom);
      dmem_if.dmem_ack   = 1'($urandom_range(0, 1));
      dmem_if.dmem_rdata = 16'($urandom);
      setExp(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    end
  endtask

  // One complete access; delay = BUSY cycle index that carries the ack (>= MAX_WAIT: never)
  task automatic applyStimulus(input logic rd, input logic wr, input logic [15:0] a,
                               input logic [15:0] wd, input logic [3:0] src,
                               input logic wbrw, input logic [3:0] wbdst,
                               input logic [15:0] wbd, input int delay,
                               input logic [15:0] mrd);
    logic [15:0] sdata;
    logic        is_rd;
    logic        tmo;
    int          busy_len;
    is_rd = rd & ~wr;
    sdata = wd;
`ifdef MEM2MEM_FWD_EN
    if (wr && wbrw && (wbdst == src) && (wbdst != 4'd0)) sdata = wbd;
`endif
    tmo      = (delay >= MAX_WAIT);
    busy_len = tmo ? MAX_WAIT : delay + 1;
    nextCycle();
    MemRead = rd; MemWrite = wr; addr = a; wdata = wd; SrcReg2 = src;
    wb_RegWrite = wbrw; wb_DstReg = wbdst; wb_data = wbd;
    dmem_if.dmem_ack   = 1'($urandom_range(0, 1));
    dmem_if.dmem_rdata = 16'($urandom);
    setExp(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    for (int k = 0; k < busy_len; k++) begin
      nextCycle();
      dmem_if.dmem_ack   = (k == delay);
      dmem_if.dmem_rdata = (k == delay) ? mrd : 16'($urandom);
      setExp(1'b1, 1'b1, wr, a, sdata, 1'b0);
    end
    nextCycle();
    dmem_if.dmem_ack   = 1'($urandom_range(0, 1));
    dmem_if.dmem_rdata = 16'($urandom);
    if (tmo) m_rdata = 16'h0;
    else if (is_rd) m_rdata = mrd;
    m_err = m_err | tmo;
    setExp(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, is_rd);
  endtask

  initial begin
    MemRead = 1'b0; MemWrite = 1'b0; addr = '0; wdata = '0; SrcReg2 = '0;
    wb_RegWrite = 1'b0; wb_DstReg = '0; wb_data = '0;
    dmem_if.dmem_ack = 1'b0; dmem_if.dmem_rdata = '0;
    m_rdata = '0; m_err = 1'b0;
    last_addr = '0; last_wdata = '0; last_we = 1'b0;
    clearCounters();
    setExp(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    $display("[TB] reset values");
    checkOutput("rst_req", 32'(dmem_if.dmem_req), 32'd0);
    checkOutput("rst_stall", 32'(mem_stall), 32'd0);
    checkOutput("rst_rdata", 32'(rdata), 32'd0);
    checkOutput("rst_rv", 32'(rdata_valid), 32'd0);
    checkOutput("rst_err", 32'(mem_err), 32'd0);
    checkOutput("rst_addr", 32'(dmem_if.dmem_addr), 32'd0);
    checkOutput("rst_wdata", 32'(dmem_if.dmem_wdata), 32'd0);
    rst = 1'b1;
    cmp_en = 1'b1;
    idleCycles(2);

    $display("[TB] load with one wait cycle");
    clearCounters();
    applyStimulus(1'b1, 1'b0, 16'h0040, 16'h0000, 4'd0, 1'b0, 4'd0, 16'h0, 1, 16'hBEEF);
    idleCycles(1);
    checkOutput("t2_stalls", 32'(stall_cnt), 32'd3);
    checkOutput("t2_req_cycles", 32'(req_cnt), 32'd2);
    checkOutput("t2_addr", 32'(last_addr), 32'h0040);
    checkOutput("t2_rdata", 32'(rdata), 32'hBEEF);
    checkOutput("t2_rv_pulses", 32'(rv_cnt), 32'd1);

    $display("[TB] store acked at once");
    clearCounters();
    applyStimulus(1'b0, 1'b1, 16'h0010, 16'h1234, 4'd0, 1'b0, 4'd0, 16'h0, 0, 16'h0);
    idleCycles(1);
    checkOutput("t3_stalls", 32'(stall_cnt), 32'd2);
    checkOutput("t3_we", 32'(last_we), 32'd1);
    checkOutput("t3_wdata", 32'(last_wdata), 32'h1234);
    checkOutput("t3_addr", 32'(last_addr), 32'h0010);
    checkOutput("t3_rdata_kept", 32'(rdata), 32'hBEEF);

    $display("[TB] back-to-back store then load");
    clearCounters();
    applyStimulus(1'b0, 1'b1, 16'h0020, 16'h1111, 4'd0, 1'b0, 4'd0, 16'h0, 0, 16'h0);
    applyStimulus(1'b1, 1'b0, 16'h0022, 16'h0000, 4'd0, 1'b0, 4'd0, 16'h0, 0, 16'h2222);
    idleCycles(1);
    checkOutput("t6_stalls", 32'(stall_cnt), 32'd4);
    checkOutput("t6_rv_pulses", 32'(rv_cnt), 32'd1);
    checkOutput("t6_rdata", 32'(rdata), 32'h2222);

    $display("[TB] load timeout");
    clearCounters();
    applyStimulus(1'b1, 1'b0, 16'h0050, 16'h0000, 4'd0, 1'b0, 4'd0, 16'h0, 99, 16'h0);
    idleCycles(1);
    checkOutput("t4_req_cycles", 32'(req_cnt), 32'd15);
    checkOutput("t4_err", 32'(mem_err), 32'd1);
    checkOutput("t4_rdata", 32'(rdata), 32'd0);
    applyStimulus(1'b1, 1'b0, 16'h0060, 16'h0000, 4'd0, 1'b0, 4'd0, 16'h0, 0, 16'h5A5A);
    idleCycles(3);
    checkOutput("t4_err_sticky", 32'(mem_err), 32'd1);
    checkOutput("t4_next_load", 32'(rdata), 32'h5A5A);

    $display("[TB] reset in the middle of BUSY");
    nextCycle();
    MemRead = 1'b1; MemWrite = 1'b0; addr = 16'h0077; wdata = 16'h0BAD;
    dmem_if.dmem_ack = 1'b0;
    setExp(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    nextCycle();
    setExp(1'b1, 1'b1, 1'b0, 16'h0077, 16'h0BAD, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("t1_req", 32'(dmem_if.dmem_req), 32'd0);
    checkOutput("t1_stall", 32'(mem_stall), 32'd0);
    checkOutput("t1_rdata", 32'(rdata), 32'd0);
    checkOutput("t1_err", 32'(mem_err), 32'd0);
    checkOutput("t1_addr", 32'(dmem_if.dmem_addr), 32'd0);
    m_rdata = 16'h0;
    m_err   = 1'b0;
    setExp(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    nextCycle();
    MemRead = 1'b0;
    rst = 1'b1;
    idleCycles(2);

`ifdef MEM2MEM_FWD_EN
    $display("[TB] Mem2Mem forwarding");
    applyStimulus(1'b0, 1'b1, 16'h0030, 16'h0000, 4'd3, 1'b1, 4'd3, 16'hA5A5, 0, 16'h0);
    idleCycles(1);
    checkOutput("t5_fwd", 32'(last_wdata), 32'hA5A5);
    applyStimulus(1'b0, 1'b1, 16'h0032, 16'h0000, 4'd0, 1'b1, 4'd0, 16'hA5A5, 0, 16'h0);
    idleCycles(1);
    checkOutput("t5_no_fwd_r0", 32'(last_wdata), 32'h0000);
`endif

    $display("[TB] randomized accesses");
    for (int n = 0; n < 60; n++) begin
      int          kind;
      int          dly;
      logic        rd, wr;
      kind = $urandom_range(0, 3);
      rd   = (kind == 0) || (kind == 2) || (kind == 3);
      wr   = (kind == 1) || (kind == 2);
      dly  = ($urandom_range(0, 9) == 0) ? $urandom_range(MAX_WAIT - 1, MAX_WAIT + 2)
                                         : $urandom_range(0, 4);
      applyStimulus(rd, wr, 16'($urandom), 16'($urandom), 4'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 16'($urandom),
                    dly, 16'($urandom));
      idleCycles($urandom_range(0, 2));
    end
    idleCycles(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
